// File: rtl/add_cycle_7_area.sv
// rtl/add_cycle_7_area.sv - fully pipelined binary32 adder, RNE, operands at edge k give a result after edge k+7.
// Define ADD7_DENORM_EN for gradual underflow; otherwise subnormal inputs/results flush to signed zero.
module add_cycle_7_area #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [EXP_W+MAN_W:0]   dataa,
  input  logic [EXP_W+MAN_W:0]   datab,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   nan,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   zero
);
  localparam int W = EXP_W + MAN_W + 1;

  // returns {exp[7:0], significand-with-hidden-bit[23:0]}
  function automatic logic [31:0] unpack(input logic [30:0] x);
    logic [7:0]  e;
    logic [23:0] m;
    e = x[30:23];
    m = {1'b1, x[22:0]};
    if (e == 8'd0) begin
`ifdef ADD7_DENORM_EN
      e = 8'd1;
      m = {1'b0, x[22:0]};
`else
      m = 24'd0;
`endif
    end
    return {e, m};
  endfunction

  logic [W-1:0]  in_a, in_b;
  logic [6:0]    vld;
  logic          s1_sa, s1_sb;
  logic [7:0]    s1_ea, s1_eb;
  logic [23:0]   s1_ma, s1_mb;
  logic [2:0]    s1_spc;
  // ctl bits: [4] special, [3] special is NaN, [2] inf sign, [1] result sign, [0] sign of an exact zero
  logic [4:0]    s2_ctl, s3_ctl, s4_ctl, s5_ctl, s6_ctl;
  logic          s2_sub, s3_sub;
  logic [7:0]    s2_e, s2_diff, s3_e, s4_e, s5_e;
  logic [23:0]   s2_mb, s2_ms;
  logic [26:0]   s3_big, s3_small;
  logic [27:0]   s4_sum, s5_sum;
  logic [4:0]    s5_lz;
  logic signed [9:0] s6_e;
  logic [26:0]   s6_m;
  logic          s6_nz;

  logic [31:0]   ua, ub;
  logic          a_nan, b_nan, a_inf, b_inf, a_big;
  logic [2:0]    spc_c;
  logic [26:0]   sm, al;
  logic          st;
  logic [4:0]    lz, sh;
  logic [26:0]   m6;
  logic signed [9:0] e6, ef;
  logic          inc;
  logic [24:0]   rm;
  logic [22:0]   mant;
  logic [31:0]   res;
  logic          f_nan, f_ov, f_uf;

  always_comb begin
    ua    = unpack(in_a[30:0]);
    ub    = unpack(in_b[30:0]);
    a_nan = (&in_a[30:23]) & (|in_a[22:0]);
    b_nan = (&in_b[30:23]) & (|in_b[22:0]);
    a_inf = (&in_a[30:23]) & ~(|in_a[22:0]);
    b_inf = (&in_b[30:23]) & ~(|in_b[22:0]);
    spc_c = {a_nan | b_nan | a_inf | b_inf,
             a_nan | b_nan | (a_inf & b_inf & (in_a[31] ^ in_b[31])),
             a_inf ? in_a[31] : in_b[31]};
    a_big = {s1_ea, s1_ma} >= {s1_eb, s1_mb};
  end

  // alignment: everything shifted past the round bit is folded into the sticky LSB
  always_comb begin
    sm = {s2_ms, 3'b000};
    if (s2_diff >= 8'd27) begin
      al = 27'd0;
      st = |s2_ms;
    end else begin
      al = sm >> s2_diff;
      st = |(sm & ~(27'h7FF_FFFF << s2_diff));
    end
    al = al | {26'd0, st};
  end

  always_comb begin
    lz = 5'd28;
    for (int i = 0; i < 28; i++)
      if (s4_sum[i]) lz = 5'(27 - i);
  end

  always_comb begin
    sh = 5'd0;
    m6 = s5_sum[27:1] | {26'd0, s5_sum[0]};
    e6 = 10'({2'b00, s5_e}) + 10'sd1;
    if (s5_lz != 5'd0) begin
      sh = s5_lz - 5'd1;
`ifdef ADD7_DENORM_EN
      // never shift below exponent 1: the result stays subnormal instead
      if ({3'd0, sh} >= s5_e) sh = 5'(s5_e - 8'd1);
`endif
      m6 = s5_sum[26:0] << sh;
      e6 = 10'({2'b00, s5_e}) - 10'(sh);
    end
  end

  always_comb begin
    inc   = s6_m[2] & (s6_m[3] | s6_m[1] | s6_m[0]);
    rm    = {1'b0, s6_m[26:3]} + {24'd0, inc};
    mant  = rm[24] ? rm[23:1] : rm[22:0];
    ef    = rm[24] ? s6_e + 10'sd1 : s6_e;
    res   = 32'd0;
    f_nan = 1'b0;
    f_ov  = 1'b0;
    f_uf  = 1'b0;
    if (s6_ctl[4]) begin
      f_nan = s6_ctl[3];
      res   = s6_ctl[3] ? 32'h7FC0_0000 : {s6_ctl[2], 8'hFF, 23'd0};
    end else if (!s6_nz) begin
      res = {s6_ctl[0], 31'd0};
`ifdef ADD7_DENORM_EN
    end else if (ef >= 10'sd255) begin
      res  = {s6_ctl[1], 8'hFF, 23'd0};
      f_ov = 1'b1;
    end else begin
      res  = {s6_ctl[1], (rm[24] | rm[23]) ? ef[7:0] : 8'd0, mant};
      f_uf = ~(rm[24] | rm[23]);
    end
`else
    end else if (s6_e <= 10'sd0) begin
      res  = {s6_ctl[1], 31'd0};
      f_uf = 1'b1;
    end else if (ef >= 10'sd255) begin
      res  = {s6_ctl[1], 8'hFF, 23'd0};
      f_ov = 1'b1;
    end else begin
      res = {s6_ctl[1], ef[7:0], mant};
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_a <= '0;  in_b <= '0;  vld <= '0;
      s1_sa <= 1'b0;  s1_sb <= 1'b0;  s1_ea <= '0;  s1_eb <= '0;
      s1_ma <= '0;  s1_mb <= '0;  s1_spc <= '0;
      s2_ctl <= '0;  s2_sub <= 1'b0;  s2_e <= '0;  s2_diff <= '0;  s2_mb <= '0;  s2_ms <= '0;
      s3_ctl <= '0;  s3_sub <= 1'b0;  s3_e <= '0;  s3_big <= '0;  s3_small <= '0;
      s4_ctl <= '0;  s4_e <= '0;  s4_sum <= '0;
      s5_ctl <= '0;  s5_e <= '0;  s5_sum <= '0;  s5_lz <= '0;
      s6_ctl <= '0;  s6_e <= '0;  s6_m <= '0;  s6_nz <= 1'b0;
      result <= '0;  nan <= 1'b0;  overflow <= 1'b0;  underflow <= 1'b0;  zero <= 1'b0;
    end else begin
      in_a     <= dataa;
      in_b     <= datab;
      vld      <= {vld[5:0], 1'b1};
      s1_sa    <= in_a[31];
      s1_sb    <= in_b[31];
      s1_ea    <= ua[31:24];
      s1_eb    <= ub[31:24];
      s1_ma    <= ua[23:0];
      s1_mb    <= ub[23:0];
      s1_spc   <= spc_c;
      s2_ctl   <= {s1_spc, a_big ? s1_sa : s1_sb, s1_sa & s1_sb};
      s2_sub   <= s1_sa ^ s1_sb;
      s2_e     <= a_big ? s1_ea : s1_eb;
      s2_diff  <= a_big ? s1_ea - s1_eb : s1_eb - s1_ea;
      s2_mb    <= a_big ? s1_ma : s1_mb;
      s2_ms    <= a_big ? s1_mb : s1_ma;
      s3_ctl   <= s2_ctl;
      s3_sub   <= s2_sub;
      s3_e     <= s2_e;
      s3_big   <= {s2_mb, 3'b000};
      s3_small <= al;
      s4_ctl   <= s3_ctl;
      s4_e     <= s3_e;
      s4_sum   <= s3_sub ? {1'b0, s3_big} - {1'b0, s3_small} : {1'b0, s3_big} + {1'b0, s3_small};
      s5_ctl   <= s4_ctl;
      s5_e     <= s4_e;
      s5_sum   <= s4_sum;
      s5_lz    <= lz;
      s6_ctl   <= s5_ctl;
      s6_e     <= e6;
      s6_m     <= m6;
      s6_nz    <= |s5_sum;
      // bubbles left behind by reset produce all-zero outputs, not a zero flag
      result    <= vld[6] ? res : '0;
      nan       <= vld[6] & f_nan;
      overflow  <= vld[6] & f_ov;
      underflow <= vld[6] & f_uf;
      zero      <= vld[6] & ~(|res[30:0]);
    end
  end
endmodule

// File: tb/tb_add_cycle_7_area.sv
// tb/tb_add_cycle_7_area.sv - directed-vector bench for add_cycle_7_area.
module tb_add_cycle_7_area;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] dataa, datab, result;
  logic        nan, overflow, underflow, zero;
  int          checks = 0;
  int          fails = 0;

  add_cycle_7_area dut (
    .clock(clock), .reset_n(reset_n), .dataa(dataa), .datab(datab),
    .result(result), .nan(nan), .overflow(overflow), .underflow(underflow), .zero(zero)
  );

  always #5 clock = ~clock;

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    dataa = a;
    datab = b;
    repeat (8) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dataa = 32'h3F80_0000;
    datab = 32'h3F80_0000;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (result !== 32'd0) begin fails++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++;
    if ({nan, overflow, underflow, zero} !== 4'b0000)
      begin fails++; $display("FAIL reset_flags: got %b expected 0000", {nan, overflow, underflow, zero}); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (i < 8 && {result, nan, overflow, underflow, zero} !== 36'd0)
        begin fails++; $display("FAIL reset_release_edge%0d: got %h/%b expected 0/0000", i, result, {nan, overflow, underflow, zero}); end
      if (i == 8 && result !== 32'h4000_0000)
        begin fails++; $display("FAIL reset_first_result: got %h expected 40000000", result); end
    end
  endtask

  task automatic test_latency();
    dataa = 32'd0;
    datab = 32'd0;
    repeat (8) @(posedge clock);
    #1;
    dataa = 32'h3F80_0000;
    datab = 32'h3F80_0000;
    @(posedge clock);
    #1;
    dataa = 32'd0;
    datab = 32'd0;
    repeat (6) @(posedge clock);
    #1;
    checks++;
    if (result !== 32'd0) begin fails++; $display("FAIL latency_early: got %h expected 00000000", result); end
    @(posedge clock);
    #1;
    checks++;
    if (result !== 32'h4000_0000) begin fails++; $display("FAIL latency_result: got %h expected 40000000", result); end
    checks++;
    if ({nan, overflow, underflow, zero} !== 4'b0000)
      begin fails++; $display("FAIL latency_flags: got %b expected 0000", {nan, overflow, underflow, zero}); end
  endtask

  task automatic test_arith();
    logic [31:0] a [5];
    logic [31:0] b [5];
    logic [31:0] e [5];
    a = '{32'h4000_0000, 32'h3F80_0000, 32'hC000_0000, 32'h4049_0FDB, 32'h3F80_0000};
    b = '{32'h4040_0000, 32'hBF00_0000, 32'h3F80_0000, 32'h0000_0000, 32'h3400_0000};
    e = '{32'h40A0_0000, 32'h3F00_0000, 32'hBF80_0000, 32'h4049_0FDB, 32'h3F80_0001};
    for (int i = 0; i < 5; i++) begin
      run_op(a[i], b[i]);
      checks++;
      if (result !== e[i]) begin fails++; $display("FAIL arith%0d: got %h expected %h", i, result, e[i]); end
      checks++;
      if ({nan, overflow, underflow, zero} !== 4'b0000)
        begin fails++; $display("FAIL arith%0d_flags: got %b expected 0000", i, {nan, overflow, underflow, zero}); end
    end
  endtask

  task automatic test_zero();
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [31:0] e [3];
    a = '{32'h3FC0_0000, 32'h8000_0000, 32'h0000_0000};
    b = '{32'hBFC0_0000, 32'h8000_0000, 32'h8000_0000};
    e = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      run_op(a[i], b[i]);
      checks++;
      if (result !== e[i]) begin fails++; $display("FAIL zero%0d: got %h expected %h", i, result, e[i]); end
      checks++;
      if ({nan, overflow, underflow, zero} !== 4'b0001)
        begin fails++; $display("FAIL zero%0d_flags: got %b expected 0001", i, {nan, overflow, underflow, zero}); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] e [4];
    logic [3:0]  f [4];
    a = '{32'h7F7F_FFFF, 32'h7F80_0000, 32'h7F80_0001, 32'hFF80_0000};
    b = '{32'h7F7F_FFFF, 32'hFF80_0000, 32'h3F80_0000, 32'h3F80_0000};
    e = '{32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000};
    f = '{4'b0100, 4'b1000, 4'b1000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      run_op(a[i], b[i]);
      checks++;
      if (result !== e[i]) begin fails++; $display("FAIL special%0d: got %h expected %h", i, result, e[i]); end
      checks++;
      if ({nan, overflow, underflow, zero} !== f[i])
        begin fails++; $display("FAIL special%0d_flags: got %b expected %b", i, {nan, overflow, underflow, zero}, f[i]); end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [31:0] e [3];
    a = '{32'h3F80_0000, 32'h3F80_0001, 32'h4B80_0000};
    b = '{32'h3380_0000, 32'h3380_0000, 32'hB380_0000};
    e = '{32'h3F80_0000, 32'h3F80_0002, 32'h4B80_0000};
    for (int i = 0; i < 3; i++) begin
      run_op(a[i], b[i]);
      checks++;
      if (result !== e[i]) begin fails++; $display("FAIL round%0d: got %h expected %h", i, result, e[i]); end
    end
  endtask

  task automatic test_underflow();
    logic [31:0] e;
    logic [3:0]  f;
`ifdef ADD7_DENORM_EN
    e = 32'h0000_0001;
    f = 4'b0010;
`else
    e = 32'h0000_0000;
    f = 4'b0011;
`endif
    run_op(32'h0080_0001, 32'h8080_0000);
    checks++;
    if (result !== e) begin fails++; $display("FAIL underflow_result: got %h expected %h", result, e); end
    checks++;
    if ({nan, overflow, underflow, zero} !== f)
      begin fails++; $display("FAIL underflow_flags: got %b expected %b", {nan, overflow, underflow, zero}, f); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [8];
    logic [31:0] b [8];
    logic [31:0] e [8];
    a = '{32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000,
          32'h3F80_0001, 32'h4B80_0000, 32'h7F80_0000, 32'hC000_0000};
    b = '{32'h3F80_0000, 32'h4040_0000, 32'hBF00_0000, 32'h3380_0000,
          32'h3380_0000, 32'hB380_0000, 32'hFF80_0000, 32'h3F80_0000};
    e = '{32'h4000_0000, 32'h40A0_0000, 32'h3F00_0000, 32'h3F80_0000,
          32'h3F80_0002, 32'h4B80_0000, 32'h7FC0_0000, 32'hBF80_0000};
    for (int c = 0; c < 15; c++) begin
      dataa = (c < 8) ? a[c] : 32'd0;
      datab = (c < 8) ? b[c] : 32'd0;
      @(posedge clock);
      #1;
      if (c >= 7) begin
        checks++;
        if (result !== e[c-7]) begin fails++; $display("FAIL b2b%0d: got %h expected %h", c - 7, result, e[c-7]); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    dataa = 32'h3F80_0000;
    datab = 32'h3F80_0000;
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (result !== 32'h4000_0000) begin fails++; $display("FAIL mid_before: got %h expected 40000000", result); end
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    dataa = 32'h4000_0000;
    datab = 32'h4040_0000;
    #1;
    checks++;
    if ({result, nan, overflow, underflow, zero} !== 36'd0)
      begin fails++; $display("FAIL mid_async_clear: got %h/%b expected 0/0000", result, {nan, overflow, underflow, zero}); end
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (i < 8 && {result, nan, overflow, underflow, zero} !== 36'd0)
        begin fails++; $display("FAIL mid_release_edge%0d: got %h/%b expected 0/0000", i, result, {nan, overflow, underflow, zero}); end
      if (i == 8 && result !== 32'h40A0_0000)
        begin fails++; $display("FAIL mid_first_result: got %h expected 40a00000", result); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    dataa = 32'd0;
    datab = 32'd0;
    test_reset();
    test_latency();
    test_arith();
    test_zero();
    test_specials();
    test_rounding();
    test_underflow();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
